// File: rtl/grid_frame_presenter_if.sv
// Bundle of game-logic, welcome-screen and renderer signals around grid_frame_presenter.
// The presenter takes the slave side; the game logic and renderer side takes master.
interface grid_frame_presenter_if #(
  parameter int GRID_N    = 4,
  parameter int TILE_BITS = 4,
  parameter int IDX_W     = $clog2(GRID_N * GRID_N)
);
  localparam int T = GRID_N * GRID_N;

  logic                   vsync;
  logic [T*TILE_BITS-1:0] grid_next;
  logic [T*TILE_BITS-1:0] welcome_grid;
  logic                   start;
  logic                   restart;
  logic                   added_valid;
  logic [IDX_W-1:0]       added_index;
  logic [T*TILE_BITS-1:0] grid_out;
  logic                   frame_strobe;
  logic                   in_welcome;
  logic [T-1:0]           new_tiles;
  logic [T-1:0]           merged_tiles;
  logic [T-1:0]           blink;

  modport master (
    output vsync, grid_next, welcome_grid, start, restart, added_valid, added_index,
    input  grid_out, frame_strobe, in_welcome, new_tiles, merged_tiles, blink
  );

  modport slave (
    input  vsync, grid_next, welcome_grid, start, restart, added_valid, added_index,
    output grid_out, frame_strobe, in_welcome, new_tiles, merged_tiles, blink
  );
endinterface

// File: rtl/grid_frame_presenter.sv
// Frame-synchronous grid latch, welcome/play mode machine and per-tile flash timers.
// Define GRID_PRESENTER_MERGE_FX_EN to add the promotion (merge) flash.
module grid_frame_presenter #(
  parameter int GRID_N       = 4,
  parameter int TILE_BITS    = 4,
  parameter int FLASH_FRAMES = 25,
  parameter int CNT_W        = 5,
  parameter int IDX_W        = $clog2(GRID_N * GRID_N)
) (
  input  logic                  clk,
  input  logic                  reset,
  grid_frame_presenter_if.slave bus
);
  localparam int T = GRID_N * GRID_N;
  localparam logic [CNT_W-1:0] FLASH_LD = CNT_W'(FLASH_FRAMES);

  typedef enum logic {S_WELCOME, S_PLAY} state_t;

  state_t                 r_state;
  logic                   r_vsync_prev;
  logic                   r_armed;
  logic                   r_frame_strobe;
  logic                   r_in_welcome;
  logic [T*TILE_BITS-1:0] r_grid_out;
  logic [CNT_W-1:0]       r_cnt [T];
  logic [T-1:0]           r_new;
  logic [T-1:0]           r_blink;

  logic                   w_edge;
  logic                   w_add_ok;
  logic [T-1:0]           w_hit;
  logic [CNT_W-1:0]       w_cnt_nxt [T];

  // r_armed blocks a false edge when vsync is already high coming out of reset
  assign w_edge   = bus.vsync & ~r_vsync_prev & r_armed;
  assign w_add_ok = bus.added_valid && (int'(bus.added_index) < T);

`ifdef GRID_PRESENTER_MERGE_FX_EN
  logic [T-1:0] r_kind;
  logic [T-1:0] r_merged;
  logic [T-1:0] w_kind_nxt;
  logic [T-1:0] w_prom;

  always_comb begin
    w_prom = '0;
    for (int i = 0; i < T; i++) begin
      w_prom[i] = w_edge &&
                  (r_grid_out[i*TILE_BITS +: TILE_BITS] != '0) &&
                  (bus.grid_next[i*TILE_BITS +: TILE_BITS] > r_grid_out[i*TILE_BITS +: TILE_BITS]);
    end
  end
`endif

  // Per-tile next count: restart/welcome clear, then spawn load, promotion load, decrement
  always_comb begin
    w_hit = '0;
`ifdef GRID_PRESENTER_MERGE_FX_EN
    w_kind_nxt = r_kind;
`endif
    for (int i = 0; i < T; i++) begin
      w_hit[i]     = w_add_ok && (int'(bus.added_index) == i);
      w_cnt_nxt[i] = r_cnt[i];
      if (r_state != S_PLAY || bus.restart) begin
        w_cnt_nxt[i] = '0;
`ifdef GRID_PRESENTER_MERGE_FX_EN
        w_kind_nxt[i] = 1'b0;
`endif
      end else if (w_hit[i]) begin
        w_cnt_nxt[i] = FLASH_LD;
`ifdef GRID_PRESENTER_MERGE_FX_EN
        w_kind_nxt[i] = 1'b0;
      end else if (w_prom[i]) begin
        w_cnt_nxt[i]  = FLASH_LD;
        w_kind_nxt[i] = 1'b1;
`endif
      end else if (w_edge && r_cnt[i] != '0) begin
        w_cnt_nxt[i] = r_cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_WELCOME;
      r_vsync_prev   <= 1'b0;
      r_armed        <= 1'b0;
      r_frame_strobe <= 1'b0;
      r_in_welcome   <= 1'b1;
      r_grid_out     <= '0;
      r_new          <= '0;
      r_blink        <= '0;
      for (int i = 0; i < T; i++) r_cnt[i] <= '0;
`ifdef GRID_PRESENTER_MERGE_FX_EN
      r_kind         <= '0;
      r_merged       <= '0;
`endif
    end else begin
      r_vsync_prev   <= bus.vsync;
      r_armed        <= r_armed | ~bus.vsync;
      r_frame_strobe <= w_edge;

      case (r_state)
        S_WELCOME: begin
          if (w_edge) begin
            r_grid_out <= bus.welcome_grid;
            if (bus.start) begin
              r_state      <= S_PLAY;
              r_in_welcome <= 1'b0;
            end
          end
        end
        S_PLAY: begin
          if (bus.restart) begin
            r_state      <= S_WELCOME;
            r_in_welcome <= 1'b1;
          end else if (w_edge) begin
            r_grid_out <= bus.grid_next;
          end
        end
        default: begin
          r_state      <= S_WELCOME;
          r_in_welcome <= 1'b1;
        end
      endcase

      for (int i = 0; i < T; i++) begin
        r_cnt[i]   <= w_cnt_nxt[i];
        r_blink[i] <= w_cnt_nxt[i][1];
`ifdef GRID_PRESENTER_MERGE_FX_EN
        r_new[i]    <= (w_cnt_nxt[i] != '0) & ~w_kind_nxt[i];
        r_merged[i] <= (w_cnt_nxt[i] != '0) &  w_kind_nxt[i];
`else
        r_new[i]    <= (w_cnt_nxt[i] != '0);
`endif
      end
`ifdef GRID_PRESENTER_MERGE_FX_EN
      r_kind <= w_kind_nxt;
`endif
    end
  end

  assign bus.grid_out     = r_grid_out;
  assign bus.frame_strobe = r_frame_strobe;
  assign bus.in_welcome   = r_in_welcome;
  assign bus.new_tiles    = r_new;
  assign bus.blink        = r_blink;
`ifdef GRID_PRESENTER_MERGE_FX_EN
  assign bus.merged_tiles = r_merged;
`else
  assign bus.merged_tiles = '0;
`endif
endmodule

// File: tb/tb_grid_frame_presenter.sv
// Directed + randomized bench for grid_frame_presenter against a frame-level reference model.
module tb_grid_frame_presenter;
  localparam int GRID_N = 4, TILE_BITS = 4, T = 16, CNT_W = 5, F = 25, IDX_W = 4;
  localparam int GW = T * TILE_BITS;
`ifdef GRID_PRESENTER_MERGE_FX_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grid_frame_presenter_if #(.GRID_N(GRID_N), .TILE_BITS(TILE_BITS), .IDX_W(IDX_W)) bus ();

  grid_frame_presenter #(
    .GRID_N(GRID_N), .TILE_BITS(TILE_BITS), .FLASH_FRAMES(F), .CNT_W(CNT_W), .IDX_W(IDX_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: frame-level view of the presenter
  bit            m_prev;     // last vsync sample; treated as high until seen low after reset
  bit            m_welcome;
  bit            m_strobe;
  logic [GW-1:0] m_grid;
  int            m_cnt [T];
  bit            m_kind [T];

  task automatic model_reset();
    m_prev    = 1'b1;
    m_welcome = 1'b1;
    m_strobe  = 1'b0;
    m_grid    = '0;
    for (int i = 0; i < T; i++) begin
      m_cnt[i]  = 0;
      m_kind[i] = 1'b0;
    end
  endtask

  task automatic model_clock();
    bit edge_now;
    logic [GW-1:0] old_grid;
    int ot, nt;
    edge_now = bus.vsync && !m_prev;
    m_prev   = bus.vsync;
    m_strobe = edge_now;
    if (m_welcome) begin
      if (edge_now) begin
        m_grid = bus.welcome_grid;
        if (bus.start) m_welcome = 1'b0;
      end
      for (int i = 0; i < T; i++) begin m_cnt[i] = 0; m_kind[i] = 1'b0; end
    end else if (bus.restart) begin
      m_welcome = 1'b1;
      for (int i = 0; i < T; i++) begin m_cnt[i] = 0; m_kind[i] = 1'b0; end
    end else begin
      old_grid = m_grid;
      if (edge_now) m_grid = bus.grid_next;
      for (int i = 0; i < T; i++) begin
        ot = int'(old_grid[i*TILE_BITS +: TILE_BITS]);
        nt = int'(bus.grid_next[i*TILE_BITS +: TILE_BITS]);
        if (bus.added_valid && int'(bus.added_index) == i) begin
          m_cnt[i] = F; m_kind[i] = 1'b0;
        end else if (MERGE && edge_now && ot != 0 && nt > ot) begin
          m_cnt[i] = F; m_kind[i] = 1'b1;
        end else if (edge_now && m_cnt[i] > 0) begin
          m_cnt[i] = m_cnt[i] - 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [T-1:0] en, em, eb;
    for (int i = 0; i < T; i++) begin
      en[i] = (m_cnt[i] != 0) && !m_kind[i];
      em[i] = (m_cnt[i] != 0) &&  m_kind[i];
      eb[i] = ((m_cnt[i] >> 1) & 1) != 0;
    end
    chk("grid_out",     bus.grid_out,            m_grid);
    chk("frame_strobe", GW'(bus.frame_strobe),   GW'(m_strobe));
    chk("in_welcome",   GW'(bus.in_welcome),     GW'(m_welcome));
    chk("new_tiles",    GW'(bus.new_tiles),      GW'(en));
    chk("merged_tiles", GW'(bus.merged_tiles),   GW'(em));
    chk("blink",        GW'(bus.blink),          GW'(eb));
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic frame(input int hi, input int lo);
    bus.vsync = 1'b1;
    repeat (hi) step();
    bus.vsync = 1'b0;
    repeat (lo) step();
  endtask

  task automatic rand_grid(output logic [GW-1:0] g);
    g = {$urandom, $urandom};
  endtask

  task automatic pulse_add(input int idx);
    bus.added_valid = 1'b1;
    bus.added_index = IDX_W'(idx);
    step();
    bus.added_valid = 1'b0;
  endtask

  initial begin
    logic [GW-1:0] g;
    int guard;
    bus.vsync = 1'b1;
    bus.start = 1'b0;
    bus.restart = 1'b0;
    bus.added_valid = 1'b0;
    bus.added_index = '0;
    rand_grid(g); bus.grid_next = g;
    rand_grid(g); bus.welcome_grid = g;
    reset = 1'b1;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // vsync held high across reset release: no edge yet
    repeat (3) step();
    bus.vsync = 1'b0;
    step();

    // Welcome frames
    for (int k = 0; k < 3; k++) begin
      rand_grid(g); bus.welcome_grid = g;
      frame(2, 6);
    end

    // Start across an edge, then play frames
    bus.start = 1'b1;
    frame(2, 2);
    bus.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rand_grid(g); bus.grid_next = g;
      frame(2, 6);
    end

    // Spawn at index 0, run 26 frames
    bus.grid_next = '0;
    pulse_add(0);
    for (int k = 0; k < 26; k++) frame(1, 4);

    // Spawn at index 5 coinciding with an edge when its count is 3
    pulse_add(5);
    pulse_add(9);
    guard = 0;
    while (m_cnt[5] != 3 && guard < 40) begin
      frame(1, 3);
      guard++;
    end
    chk("idx5_reached_3", GW'(guard < 40), GW'(1));
    bus.vsync = 1'b1;
    pulse_add(5);
    bus.vsync = 1'b0;
    for (int k = 0; k < 4; k++) frame(1, 3);
    chk("idx5_reloaded", GW'(bus.new_tiles[5]), GW'(1));

    // Randomized play
    for (int c = 0; c < 400; c++) begin
      bus.vsync = (c % 8) < 2;
      if ((c % 8) == 4) begin rand_grid(g); bus.grid_next = g; end
      bus.added_valid = ($urandom_range(0, 5) == 0);
      bus.added_index = IDX_W'($urandom_range(0, T - 1));
      step();
    end
    bus.added_valid = 1'b0;

    // Restart mid-frame while three tiles flash
    bus.vsync = 1'b0;
    pulse_add(1);
    pulse_add(2);
    pulse_add(3);
    step();
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    chk("restart_masks", GW'(bus.new_tiles), GW'(0));
    rand_grid(g); bus.welcome_grid = g;
    frame(2, 4);

    // Tile 7 promotion 2 -> 3
    bus.start = 1'b1;
    frame(1, 3);
    bus.start = 1'b0;
    g = '0; g[7*TILE_BITS +: TILE_BITS] = 4'd2; bus.grid_next = g;
    frame(1, 3);
    g[7*TILE_BITS +: TILE_BITS] = 4'd3; bus.grid_next = g;
    frame(1, 3);
    chk("tile7_merged", GW'(bus.merged_tiles[7]), GW'(MERGE));
    chk("tile7_new",    GW'(bus.new_tiles[7]),    GW'(0));
    frame(1, 3);

    // Asynchronous reset mid-frame
    step();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    rand_grid(g); bus.welcome_grid = g;
    frame(2, 4);
    frame(2, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
